log_reservation_station: RTL and testbench
==========================================

Name: log_reservation_station

Overview:
- Reservation station and issue scheduler in front of the logic unit (AND/OR/XOR/NAND/NOR/EQV/ANDC/ORC/EXTSB/EXTSH/CNTLZW).
- Accepts dispatched logic ops whose operands are either values or producer tags.
- Snoops the common result bus to resolve tags.
- Issues ready entries to the logic unit's valid/ready input port using round-robin fairness.

Parameters:
- RS_DEPTH, 4, number of entries (2..8).
- RS_ID_WIDTH, 5, width of producer and entry tags.
- RS_OFFSET, 0, global tag of entry 0; entry i has tag RS_OFFSET+i.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dispatch_valid  in  1  dispatch request
- dispatch_ready  out  1  free entry available
- dispatch_rs_id  out  RS_ID_WIDTH  tag of the entry that would be allocated this cycle
- op1_valid_in / op2_valid_in  in  1  operand holds a value (1) or a tag (0)
- op1_in / op2_in  in  32  operand value
- op1_rs_id_in / op2_rs_id_in  in  RS_ID_WIDTH  producer tag when not valid
- so_in  in  1  XER[SO] snapshot
- control_in  in  log_decode_t  operation and alter_CR0
- result_reg_addr_in  in  5  destination GPR
- cdb_valid  in  1  result bus broadcast
- cdb_rs_id  in  RS_ID_WIDTH  broadcast tag
- cdb_result  in  32  broadcast value
- flush  in  1  discard all entries
- issue_valid  out  1  to logic unit input_valid
- issue_ready  in  1  from logic unit input_ready
- issue_rs_id  out  RS_ID_WIDTH  entry tag
- issue_result_reg_addr  out  5  destination GPR
- issue_op1 / issue_op2  out  32  resolved operands
- issue_so  out  1  SO snapshot
- issue_control  out  log_decode_t  operation

Behaviour:
- Per-entry state: busy, op1/op2 ready flags, values, tags, so, control, reg_addr.
- Reset: all busy=0, rr_ptr=0, lock=0; issue_valid=0, dispatch_ready=1, dispatch_rs_id=RS_OFFSET, all other issue_* outputs 0.
- Allocation:
  - Lowest-index non-busy entry. dispatch_ready = any non-busy, computed from registered busy bits only.
  - An entry freed by issue this cycle is reusable next cycle, not the same cycle.
  - Handshake dispatch_valid&dispatch_ready writes the entry and sets busy on the next edge.
- Operand capture:
  - A not-valid operand whose tag equals cdb_rs_id while cdb_valid is high in the dispatch cycle is stored as ready with cdb_result (same-cycle forward).
  - Busy entries waiting on a tag capture cdb_result on match. The operand becomes ready in the following cycle and is issuable from the cycle after the capture edge.
  - Both operands may match the same broadcast.
- Issue selection:
  - Candidate = busy entry with both operands ready.
  - Pick the first candidate at or after rr_ptr, wrapping modulo RS_DEPTH.
  - issue_* outputs are combinational from the selected entry.
- Stability lock:
  - When issue_valid=1 and issue_ready=0, set lock and hold the selected index.
  - While locked, issue_valid and all issue_* outputs stay unchanged until handshake.
- Issue handshake (issue_valid&issue_ready):
  - Clear that entry's busy bit.
  - Set rr_ptr = selected index + 1, wrapping to 0 after RS_DEPTH-1.
  - Clear lock.
- Empty or no candidate: issue_valid=0; rr_ptr is unchanged.
- Full: dispatch_ready=0. A dispatch_valid held high is accepted the cycle after an issue frees an entry.
- Flush:
  - Clears busy, lock and rr_ptr at the next edge.
  - Takes priority over a same-cycle dispatch, which is dropped, and over issue.
  - issue_valid is still driven combinationally in the flush cycle. The downstream unit must also be flushed.
- Simultaneous dispatch, snoop and issue in one cycle are all legal and independent.

Optional Feature:
- Macro LOG_RS_PERF_COUNTERS_EN.
- Defined: adds outputs perf_full_cycles (32) and perf_stall_cycles (32).
  - perf_full_cycles counts cycles with dispatch_valid&~dispatch_ready.
  - perf_stall_cycles counts cycles with issue_valid&~issue_ready.
  - Both saturate at 32'hFFFF_FFFF, are cleared by rst and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Ready dispatch:
  - Stimulus: after reset, dispatch op1=32'hF0F0_0000 and op2=32'h0FF0_0000, both valid, LOG_AND, reg 3, issue_ready=1.
  - Expected: dispatch_rs_id=RS_OFFSET; next cycle issue_valid=1 with op1/op2 as given, issue_rs_id=RS_OFFSET, issue_result_reg_addr=3.
- Tag wakeup:
  - Stimulus: dispatch op2 as tag 5'd9; two cycles later cdb_valid with tag 9, result 32'h1234_5678.
  - Expected: issue_valid=0 until the cycle after the broadcast edge, then issue_op2=32'h1234_5678.
- Same-cycle forward:
  - Stimulus: dispatch op1 as tag 7 while cdb_valid with tag 7, result 32'hDEAD_BEEF.
  - Expected: next cycle issue_op1=32'hDEAD_BEEF with no further broadcast needed.
- Full and backpressure:
  - Stimulus: issue_ready=0, fill 4 entries.
  - Expected: dispatch_ready=0 and issue_* stable over 10 cycles. After issue_ready=1, entry 0 issues, then entries 1, 2, 3 in consecutive cycles. A pending 5th dispatch is accepted into entry 0 the cycle after entry 0 issues.
- Round-robin fairness:
  - Stimulus: entries 0 and 2 always ready.
  - Expected: issue order 0, 2, 0, 2 with re-dispatch into each freed entry; neither is issued twice in a row.
- Flush:
  - Stimulus: 3 busy entries, lock set, assert flush together with a dispatch.
  - Expected: next cycle issue_valid=0, dispatch_ready=1, dispatch_rs_id=RS_OFFSET; the flushed dispatch never issues.

Source files
------------

// File: rtl/log_reservation_station.sv
// rtl/log_reservation_station.sv - logic-unit reservation station with tag snooping and round-robin issue
// Optional perf counters are compiled in when LOG_RS_PERF_COUNTERS_EN is defined.
module log_reservation_station #(
    parameter int RS_DEPTH    = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0,
    parameter int CTRL_WIDTH  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    input  logic                   op1_valid_in,
    input  logic                   op2_valid_in,
    input  logic [31:0]            op1_in,
    input  logic [31:0]            op2_in,
    input  logic [RS_ID_WIDTH-1:0] op1_rs_id_in,
    input  logic [RS_ID_WIDTH-1:0] op2_rs_id_in,
    input  logic                   so_in,
    input  logic [CTRL_WIDTH-1:0]  control_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    input  logic                   flush,
`ifdef LOG_RS_PERF_COUNTERS_EN
    output logic [31:0]            perf_full_cycles,
    output logic [31:0]            perf_stall_cycles,
`endif
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [4:0]             issue_result_reg_addr,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output logic                   issue_so,
    output logic [CTRL_WIDTH-1:0]  issue_control
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    typedef logic [IDX_W-1:0] idx_t;
    localparam logic [RS_ID_WIDTH-1:0] TAG_BASE = RS_ID_WIDTH'(RS_OFFSET);

    logic [RS_DEPTH-1:0]    busy, op1_rdy, op2_rdy, so_q;
    logic [31:0]            op1_val [RS_DEPTH];
    logic [31:0]            op2_val [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0] op1_tag [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0] op2_tag [RS_DEPTH];
    logic [CTRL_WIDTH-1:0]  ctl_q   [RS_DEPTH];
    logic [4:0]             rd_q    [RS_DEPTH];

    idx_t rr_ptr, lock_idx, alloc_idx, cand_idx, sel_idx;
    logic lock, cand_found, issue_fire, dispatch_fire, fwd1, fwd2;

    // Allocation looks only at registered busy bits, so a slot freed by issue is reused next cycle.
    always_comb begin
        alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = idx_t'(i);
        end
    end

    assign dispatch_ready = ~&busy;
    assign dispatch_rs_id = TAG_BASE + RS_ID_WIDTH'(alloc_idx);
    assign dispatch_fire  = dispatch_valid & dispatch_ready;
    assign fwd1 = cdb_valid && (op1_rs_id_in == cdb_rs_id);
    assign fwd2 = cdb_valid && (op2_rs_id_in == cdb_rs_id);

    // Scan downward so the candidate closest to rr_ptr wins.
    always_comb begin
        int   j;
        idx_t jj;
        cand_found = 1'b0;
        cand_idx   = '0;
        j          = 0;
        jj         = '0;
        for (int k = RS_DEPTH - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= RS_DEPTH) j = j - RS_DEPTH;
            jj = idx_t'(j);
            if (busy[jj] && op1_rdy[jj] && op2_rdy[jj]) begin
                cand_found = 1'b1;
                cand_idx   = jj;
            end
        end
    end

    assign sel_idx     = lock ? lock_idx : cand_idx;
    assign issue_valid = lock | cand_found;
    assign issue_fire  = issue_valid & issue_ready;

    always_comb begin
        issue_rs_id           = '0;
        issue_result_reg_addr = '0;
        issue_op1             = '0;
        issue_op2             = '0;
        issue_so              = 1'b0;
        issue_control         = '0;
        if (issue_valid) begin
            issue_rs_id           = TAG_BASE + RS_ID_WIDTH'(sel_idx);
            issue_result_reg_addr = rd_q[sel_idx];
            issue_op1             = op1_val[sel_idx];
            issue_op2             = op2_val[sel_idx];
            issue_so              = so_q[sel_idx];
            issue_control         = ctl_q[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy     <= '0;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy[i] && cdb_valid && !op1_rdy[i] && op1_tag[i] == cdb_rs_id) begin
                    op1_rdy[i] <= 1'b1;
                    op1_val[i] <= cdb_result;
                end
                if (busy[i] && cdb_valid && !op2_rdy[i] && op2_tag[i] == cdb_rs_id) begin
                    op2_rdy[i] <= 1'b1;
                    op2_val[i] <= cdb_result;
                end
            end
            if (issue_fire) begin
                busy[sel_idx] <= 1'b0;
                rr_ptr        <= (sel_idx == idx_t'(RS_DEPTH - 1)) ? '0 : sel_idx + 1'b1;
                lock          <= 1'b0;
            end else if (issue_valid) begin
                lock     <= 1'b1;
                lock_idx <= sel_idx;
            end
            if (dispatch_fire) begin
                busy[alloc_idx]    <= 1'b1;
                op1_rdy[alloc_idx] <= op1_valid_in | fwd1;
                op2_rdy[alloc_idx] <= op2_valid_in | fwd2;
                op1_val[alloc_idx] <= op1_valid_in ? op1_in : cdb_result;
                op2_val[alloc_idx] <= op2_valid_in ? op2_in : cdb_result;
                op1_tag[alloc_idx] <= op1_rs_id_in;
                op2_tag[alloc_idx] <= op2_rs_id_in;
                so_q[alloc_idx]    <= so_in;
                ctl_q[alloc_idx]   <= control_in;
                rd_q[alloc_idx]    <= result_reg_addr_in;
            end
        end
    end

`ifdef LOG_RS_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (dispatch_valid && !dispatch_ready && perf_full_cycles != 32'hFFFF_FFFF)
                perf_full_cycles <= perf_full_cycles + 32'd1;
            if (issue_valid && !issue_ready && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_log_reservation_station.sv
// tb/tb_log_reservation_station.sv - directed bench for log_reservation_station
module tb_log_reservation_station;
    localparam int OFF = 16;
    localparam logic [4:0] C_AND   = {4'd0, 1'b0};
    localparam logic [4:0] C_OR_RC = {4'd1, 1'b1};
    localparam logic [4:0] C_XOR   = {4'd2, 1'b0};

    logic        clk = 1'b0;
    logic        rst, dispatch_valid, dispatch_ready;
    logic [4:0]  dispatch_rs_id;
    logic        op1_valid_in, op2_valid_in;
    logic [31:0] op1_in, op2_in;
    logic [4:0]  op1_rs_id_in, op2_rs_id_in;
    logic        so_in;
    logic [4:0]  control_in, result_reg_addr_in;
    logic        cdb_valid;
    logic [4:0]  cdb_rs_id;
    logic [31:0] cdb_result;
    logic        flush, issue_valid, issue_ready;
    logic [4:0]  issue_rs_id, issue_result_reg_addr;
    logic [31:0] issue_op1, issue_op2;
    logic        issue_so;
    logic [4:0]  issue_control;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    log_reservation_station #(.RS_DEPTH(4), .RS_ID_WIDTH(5), .RS_OFFSET(OFF), .CTRL_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_rs_id(dispatch_rs_id),
        .op1_valid_in(op1_valid_in), .op2_valid_in(op2_valid_in),
        .op1_in(op1_in), .op2_in(op2_in),
        .op1_rs_id_in(op1_rs_id_in), .op2_rs_id_in(op2_rs_id_in),
        .so_in(so_in), .control_in(control_in), .result_reg_addr_in(result_reg_addr_in),
        .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
        .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
        .issue_result_reg_addr(issue_result_reg_addr),
        .issue_op1(issue_op1), .issue_op2(issue_op2),
        .issue_so(issue_so), .issue_control(issue_control)
    );

    typedef struct {
        logic        dv;
        logic        o1v;
        logic [31:0] o1;
        logic [4:0]  t1;
        logic        o2v;
        logic [31:0] o2;
        logic [4:0]  t2;
        logic [4:0]  rd;
        logic [4:0]  ctl;
        logic        so;
        logic        cv;
        logic [4:0]  ct;
        logic [31:0] cr;
        logic        e_dr;
        logic [4:0]  e_did;
        logic        e_iv;
        logic [4:0]  e_iid;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [4:0]  e_rd;
        logic [4:0]  e_ctl;
        logic        e_so;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        dispatch_valid = 0; op1_valid_in = 0; op2_valid_in = 0;
        op1_in = '0; op2_in = '0; op1_rs_id_in = '0; op2_rs_id_in = '0;
        so_in = 0; control_in = '0; result_reg_addr_in = '0;
        cdb_valid = 0; cdb_rs_id = '0; cdb_result = '0; flush = 0;
    endtask

    task automatic disp_ready_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        idle();
        dispatch_valid = 1; op1_valid_in = 1; op2_valid_in = 1;
        op1_in = a; op2_in = b; result_reg_addr_in = rd; control_in = C_AND;
    endtask

    task automatic disp_wait_op(input logic [4:0] tag, input logic [4:0] rd);
        idle();
        dispatch_valid = 1; op1_valid_in = 0; op2_valid_in = 1;
        op1_rs_id_in = tag; op2_in = 32'h5; result_reg_addr_in = rd; control_in = C_AND;
    endtask

    task automatic do_reset();
        idle();
        issue_ready = 0;
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #2;
        chk("reset issue_valid", 32'(issue_valid), 32'd0);
        chk("reset dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("reset dispatch_rs_id", 32'(dispatch_rs_id), 32'(OFF));
        chk("reset issue_op1", issue_op1, 32'd0);
        chk("reset issue_rs_id", 32'(issue_rs_id), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_id [4];
        logic [31:0] exp_op [4];

        //         dv o1v o1            t1     o2v o2            t2     rd     ctl      so cv ct     cr            e_dr e_did   e_iv e_iid   e_op1         e_op2         e_rd   e_ctl    e_so
        vecs[0]  = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd16, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[1]  = '{1, 1, 32'hF0F0_0000, 5'd0,  1, 32'h0FF0_0000, 5'd0,  5'd3, C_AND,   1, 0, 5'd0,  32'h0,        1, 5'd16, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[2]  = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd17, 1, 5'd16, 32'hF0F0_0000, 32'h0FF0_0000, 5'd3, C_AND,   1};
        vecs[3]  = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd16, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[4]  = '{1, 1, 32'h0000_00FF, 5'd0,  0, 32'h0,         5'd9,  5'd4, C_OR_RC, 0, 0, 5'd0,  32'h0,        1, 5'd16, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[5]  = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd17, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[6]  = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 1, 5'd9,  32'h1234_5678, 1, 5'd17, 0, 5'd0, 32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[7]  = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd17, 1, 5'd16, 32'h0000_00FF, 32'h1234_5678, 5'd4, C_OR_RC, 0};
        vecs[8]  = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd16, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[9]  = '{1, 0, 32'h0,         5'd7,  1, 32'h0000_0F0F, 5'd0,  5'd5, C_XOR,   0, 1, 5'd7,  32'hDEAD_BEEF, 1, 5'd16, 0, 5'd0, 32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[10] = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd17, 1, 5'd16, 32'hDEAD_BEEF, 32'h0000_0F0F, 5'd5, C_XOR,   0};
        vecs[11] = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd16, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[12] = '{1, 0, 32'h0,         5'd11, 0, 32'h0,         5'd11, 5'd6, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd16, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[13] = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 1, 5'd12, 32'h0000_0001, 1, 5'd17, 0, 5'd0, 32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[14] = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 1, 5'd11, 32'hAAAA_5555, 1, 5'd17, 0, 5'd0, 32'h0,        32'h0,        5'd0, C_AND,   0};
        vecs[15] = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd17, 1, 5'd16, 32'hAAAA_5555, 32'hAAAA_5555, 5'd6, C_AND,   0};
        vecs[16] = '{0, 0, 32'h0,         5'd0,  0, 32'h0,         5'd0,  5'd0, C_AND,   0, 0, 5'd0,  32'h0,        1, 5'd16, 0, 5'd0,  32'h0,        32'h0,        5'd0, C_AND,   0};

        do_reset();
        issue_ready = 1;
        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            dispatch_valid = vecs[n].dv;  op1_valid_in = vecs[n].o1v; op1_in = vecs[n].o1;
            op1_rs_id_in = vecs[n].t1;    op2_valid_in = vecs[n].o2v; op2_in = vecs[n].o2;
            op2_rs_id_in = vecs[n].t2;    result_reg_addr_in = vecs[n].rd;
            control_in = vecs[n].ctl;     so_in = vecs[n].so;
            cdb_valid = vecs[n].cv;       cdb_rs_id = vecs[n].ct; cdb_result = vecs[n].cr;
            #2;
            chk($sformatf("v%0d dispatch_ready", n), 32'(dispatch_ready), 32'(vecs[n].e_dr));
            chk($sformatf("v%0d dispatch_rs_id", n), 32'(dispatch_rs_id), 32'(vecs[n].e_did));
            chk($sformatf("v%0d issue_valid", n), 32'(issue_valid), 32'(vecs[n].e_iv));
            if (vecs[n].e_iv) begin
                chk($sformatf("v%0d issue_rs_id", n), 32'(issue_rs_id), 32'(vecs[n].e_iid));
                chk($sformatf("v%0d issue_op1", n), issue_op1, vecs[n].e_op1);
                chk($sformatf("v%0d issue_op2", n), issue_op2, vecs[n].e_op2);
                chk($sformatf("v%0d issue_rd", n), 32'(issue_result_reg_addr), 32'(vecs[n].e_rd));
                chk($sformatf("v%0d issue_control", n), 32'(issue_control), 32'(vecs[n].e_ctl));
                chk($sformatf("v%0d issue_so", n), 32'(issue_so), 32'(vecs[n].e_so));
            end
        end

        // Full and backpressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            disp_ready_op(32'h100 + 32'(i), 32'h200 + 32'(i), 5'(i + 1));
            #2;
            chk($sformatf("fill%0d dispatch_ready", i), 32'(dispatch_ready), 32'd1);
            chk($sformatf("fill%0d dispatch_rs_id", i), 32'(dispatch_rs_id), 32'(OFF + i));
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            disp_ready_op(32'h500, 32'h600, 5'd9);
            #2;
            chk($sformatf("full%0d dispatch_ready", c), 32'(dispatch_ready), 32'd0);
            chk($sformatf("full%0d issue_valid", c), 32'(issue_valid), 32'd1);
            chk($sformatf("full%0d issue_rs_id", c), 32'(issue_rs_id), 32'(OFF));
            chk($sformatf("full%0d issue_op1", c), issue_op1, 32'h100);
            chk($sformatf("full%0d issue_rd", c), 32'(issue_result_reg_addr), 32'd1);
        end
        exp_id = '{OFF, OFF + 1, OFF + 2, OFF + 3};
        exp_op = '{32'h100, 32'h101, 32'h102, 32'h103};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            issue_ready = 1;
            if (c >= 2) dispatch_valid = 0;
            #2;
            chk($sformatf("drain%0d issue_valid", c), 32'(issue_valid), 32'd1);
            chk($sformatf("drain%0d issue_rs_id", c), 32'(issue_rs_id), 32'(exp_id[c]));
            chk($sformatf("drain%0d issue_op1", c), issue_op1, exp_op[c]);
            if (c == 0) chk("drain0 dispatch_ready", 32'(dispatch_ready), 32'd0);
            if (c == 1) begin
                chk("drain1 dispatch_ready", 32'(dispatch_ready), 32'd1);
                chk("drain1 dispatch_rs_id", 32'(dispatch_rs_id), 32'(OFF));
            end
        end
        @(negedge clk);
        #2;
        chk("fifth issue_rs_id", 32'(issue_rs_id), 32'(OFF));
        chk("fifth issue_op1", issue_op1, 32'h500);
        @(negedge clk);
        #2;
        chk("drained issue_valid", 32'(issue_valid), 32'd0);

        // Round-robin fairness: entries 1 and 3 wait on tags never broadcast
        do_reset();
        @(negedge clk); disp_ready_op(32'hA0, 32'h0, 5'd1);
        @(negedge clk); disp_wait_op(5'd20, 5'd2);
        @(negedge clk); disp_ready_op(32'hC0, 32'h0, 5'd3);
        @(negedge clk); disp_wait_op(5'd21, 5'd4);
        exp_id = '{OFF, OFF + 2, OFF, OFF + 2};
        exp_op = '{32'hA0, 32'hC0, 32'hE1, 32'hE2};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            issue_ready = 1;
            disp_ready_op(32'hE0 + 32'(k), 32'h0, 5'd7);
            #2;
            chk($sformatf("rr%0d issue_valid", k), 32'(issue_valid), 32'd1);
            chk($sformatf("rr%0d issue_rs_id", k), 32'(issue_rs_id), 32'(exp_id[k]));
            chk($sformatf("rr%0d issue_op1", k), issue_op1, exp_op[k]);
        end

        // Flush with lock held and a same-cycle dispatch
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            disp_ready_op(32'h10 + 32'(i), 32'h0, 5'(i + 1));
        end
        @(negedge clk);
        disp_ready_op(32'hBAD, 32'h0, 5'd31);
        flush = 1;
        #2;
        chk("flush-cycle issue_valid", 32'(issue_valid), 32'd1);
        chk("flush-cycle issue_rs_id", 32'(issue_rs_id), 32'(OFF));
        @(negedge clk);
        idle();
        issue_ready = 1;
        #2;
        chk("post-flush issue_valid", 32'(issue_valid), 32'd0);
        chk("post-flush dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("post-flush dispatch_rs_id", 32'(dispatch_rs_id), 32'(OFF));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2;
            chk($sformatf("flushed%0d issue_valid", c), 32'(issue_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
